// File: rtl/pll_sup_pkg.sv
// Shared state codes and width helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // FSM state codes; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchroniser for a single async level, with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer, lock qualifier and heartbeat rate checker on the reference clock.
module pll_lock_supervisor import pll_sup_pkg::*; #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int HB_WINDOW     = 1000,
  parameter int HB_MIN        = 56,
  parameter int HB_MAX        = 69
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       hb_tgl,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       fault,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int TW = clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, HB_WINDOW));

  localparam logic [TW-1:0] T_RST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_WIN  = TW'(HB_WINDOW - 1);
  localparam logic [7:0]    HB_LO  = 8'(HB_MIN);
  localparam logic [7:0]    HB_HI  = 8'(HB_MAX);
  localparam logic [2:0]    R_MAX  = 3'(MAX_RETRY);

  state_t        st, st_nxt;
  logic [TW-1:0] timer;
  logic [7:0]    hb_cnt, hb_eff;
  logic [2:0]    retry_inc;
  logic          locked_s, hb_s2, hb_s3, hb_edge;
  logic          win_end, hb_bad, fail, win_ok;

  sync2 #(.RST_VAL(1'b0)) u_sync_lock (
    .gclk(clkin), .grst_n(rst_n), .d(locked), .q(locked_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_hb (
    .gclk(clkin), .grst_n(rst_n), .d(hb_tgl), .q(hb_s2)
  );

  // Third heartbeat flop; any change between stage 2 and 3 is one edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) hb_s3 <= 1'b0;
    else        hb_s3 <= hb_s2;
  end

  assign hb_edge   = hb_s2 ^ hb_s3;
  // Edge on the closing cycle still belongs to the closing window.
  assign hb_eff    = (hb_edge && hb_cnt != 8'hFF) ? hb_cnt + 8'd1 : hb_cnt;
  assign win_end   = (timer == T_WIN);
  assign hb_bad    = (hb_eff < HB_LO) || (hb_eff > HB_HI);
  assign retry_inc = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
  assign state     = st;

  // Next-state logic; lock loss and a bad window collapse into one fail.
  always_comb begin
    st_nxt = st;
    fail   = 1'b0;
    win_ok = 1'b0;
    case (st)
      S_PLLRST: if (timer == T_RST) st_nxt = S_WAIT;
      S_WAIT: begin
        if (locked_s)             st_nxt = S_STABLE;
        else if (timer == T_LOCK) fail   = 1'b1;
      end
      S_STABLE: begin
        if (!locked_s)            fail   = 1'b1;
        else if (timer == T_STAB) st_nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s || (win_end && hb_bad)) fail   = 1'b1;
        else if (win_end)                     win_ok = 1'b1;
      end
      S_FAULT: st_nxt = S_FAULT;
      default: st_nxt = S_PLLRST;
    endcase
    if (fail) st_nxt = (retry_inc == R_MAX) ? S_FAULT : S_PLLRST;
  end

  // State register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) st <= S_PLLRST;
    else        st <= st_nxt;
  end

  // Shared timer: restarts on every state change and at each good window end.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                       timer <= '0;
    else if (st_nxt != st || win_ok)  timer <= '0;
    else if (st != S_FAULT)           timer <= timer + 1'b1;
  end

  // Heartbeat edge count, live only inside a RUN window.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                                       hb_cnt <= '0;
    else if (st != S_RUN || st_nxt != S_RUN || win_ok) hb_cnt <= '0;
    else                                              hb_cnt <= hb_eff;
  end

  // Failed-attempt counter; a full good window proves recovery.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)      retry_cnt <= '0;
    else if (fail)   retry_cnt <= retry_inc;
    else if (win_ok) retry_cnt <= '0;
  end

  // Outputs registered off the next state so they move on the transition edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_ok   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst   <= (st_nxt == S_PLLRST) || (st_nxt == S_FAULT);
      sys_rst_n <= (st_nxt == S_RUN);
      lock_ok   <= (st_nxt == S_RUN);
      fault     <= (st_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a queue of expected results.
module tb_pll_lock_supervisor;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       hb_auto = 1'b0;
  logic       hb_man = 1'b0;
  wire        hb_tgl;
  logic       pll_rst, sys_rst_n, lock_ok, fault;
  logic [2:0] retry_cnt, state;
  int         hb_per = 16;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntotal = 0;

  assign hb_tgl = hb_auto ^ hb_man;

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(32), .MAX_RETRY(3),
    .HB_WINDOW(200), .HB_MIN(10), .HB_MAX(15)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .locked(locked), .hb_tgl(hb_tgl),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_ok(lock_ok), .fault(fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clkin = ~clkin;

  // Free-running heartbeat toggler; period 0 parks it.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clkin);
      #1;
      if (hb_per != 0) begin
        c++;
        if (c >= hb_per) begin
          c = 0;
          hb_auto = ~hb_auto;
        end
      end else begin
        c = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      e.tag = "sb_empty";
      e.val = -1;
    end else begin
      e = sbq.pop_front();
    end
    ntotal++;
    assert (obs === 32'(e.val)) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
  endtask

  // Length of the current pll_rst run at level lvl, sampled on falling edges.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (pll_rst === lvl && n < 1000) begin
      @(negedge clkin);
      n++;
    end
  endtask

  task automatic wait_sysrst(input logic lvl, input int lim);
    int n;
    n = 0;
    while (sys_rst_n !== lvl && n < lim) begin
      @(negedge clkin);
      n++;
    end
  endtask

  initial begin
    int n, fall, hi;
    logic [2:0] r3, s3;

    // Reset values with the clock running under reset.
    push("rst_pll_rst", 1); push("rst_sys_rst_n", 0); push("rst_lock_ok", 0);
    push("rst_fault", 0); push("rst_retry", 0); push("rst_state", 0);
    repeat (3) @(negedge clkin);
    pop_chk(pll_rst); pop_chk(sys_rst_n); pop_chk(lock_ok);
    pop_chk(fault); pop_chk(retry_cnt); pop_chk(state);

    // 1. Normal start.
    push("t1_pllrst_width", 4); push("t1_sysrst_delay", 35);
    push("t1_lock_ok", 1); push("t1_retry", 0); push("t1_state", 3);
    rst_n = 1'b1;
    run_len(1'b1, n);
    pop_chk(n);
    repeat (16) @(negedge clkin);
    locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 200) begin
      @(negedge clkin);
      n++;
    end
    pop_chk(n); pop_chk(lock_ok); pop_chk(retry_cnt); pop_chk(state);
    push("t1_run_state", 3); push("t1_run_retry", 0);
    repeat (420) @(negedge clkin);
    pop_chk(state); pop_chk(retry_cnt);

    // 3. Lock loss in RUN for 5 cycles.
    push("t3_sysrst_fall", 3); push("t3_retry", 1); push("t3_state", 0);
    push("t3_pllrst_width", 4);
    locked = 1'b0;
    fall = 0; hi = 0; r3 = '0; s3 = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clkin);
      #1;
      if (i == 5) locked = 1'b1;
      @(negedge clkin);
      if (sys_rst_n === 1'b0 && fall == 0) begin
        fall = i;
        r3 = retry_cnt;
        s3 = state;
      end
      if (pll_rst === 1'b1) hi++;
    end
    pop_chk(fall); pop_chk(r3); pop_chk(s3); pop_chk(hi);
    push("t3_rerun_state", 3); push("t3_rerun_retry", 1);
    wait_sysrst(1'b1, 200);
    pop_chk(state); pop_chk(retry_cnt);
    push("t3_window_retry", 0); push("t3_window_state", 3);
    repeat (205) @(negedge clkin);
    pop_chk(retry_cnt); pop_chk(state);

    // 4. Slow heartbeat: 5 edges per window, three failures to fault.
    push("t4_first_retry", 1); push("t4_first_state", 0);
    hb_per = 40;
    n = 0;
    while (state === 3'd3 && n < 400) begin
      @(negedge clkin);
      n++;
    end
    pop_chk(retry_cnt); pop_chk(state);
    push("t4_fault", 1); push("t4_state", 4); push("t4_retry", 3);
    push("t4_pll_rst", 1); push("t4_sys_rst_n", 0); push("t4_lock_ok", 0);
    n = 0;
    while (fault !== 1'b1 && n < 2000) begin
      @(negedge clkin);
      n++;
    end
    pop_chk(fault); pop_chk(state); pop_chk(retry_cnt);
    pop_chk(pll_rst); pop_chk(sys_rst_n); pop_chk(lock_ok);

    // 2. Lock timeout with locked held low.
    rst_n = 1'b0;
    locked = 1'b0;
    hb_per = 16;
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    push("t2_wait1", 100); push("t2_retry1", 1); push("t2_state1", 0);
    push("t2_pulse2", 4);  push("t2_wait2", 100); push("t2_retry2", 2);
    push("t2_pulse3", 4);  push("t2_wait3", 100);
    push("t2_fault", 1); push("t2_state", 4); push("t2_retry", 3);
    push("t2_sys_rst_n", 0);
    run_len(1'b1, n);
    run_len(1'b0, n); pop_chk(n); pop_chk(retry_cnt); pop_chk(state);
    run_len(1'b1, n); pop_chk(n);
    run_len(1'b0, n); pop_chk(n); pop_chk(retry_cnt);
    run_len(1'b1, n); pop_chk(n);
    run_len(1'b0, n); pop_chk(n);
    pop_chk(fault); pop_chk(state); pop_chk(retry_cnt); pop_chk(sys_rst_n);

    // 5. Edge on the window's last cycle, then lock loss coinciding with a bad window.
    rst_n = 1'b0;
    hb_per = 0;
    locked = 1'b1;
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    wait_sysrst(1'b1, 200);
    push("t5_lastedge_state", 3); push("t5_lastedge_retry", 0);
    push("t5_coincide_retry", 1); push("t5_coincide_state", 0);
    push("t5_coincide_sysrst", 0);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clkin);
      #1;
      if (k <= 90 && (k % 10) == 0) hb_man = ~hb_man;
      if (k == 197) hb_man = ~hb_man;
      if (k == 397) locked = 1'b0;
      if (k == 205) begin
        pop_chk(state);
        pop_chk(retry_cnt);
      end
    end
    pop_chk(retry_cnt); pop_chk(state); pop_chk(sys_rst_n);

    // 6. Async reset while counting in S_STABLE.
    locked = 1'b1;
    push("t6_in_stable", 2);
    n = 0;
    while (state !== 3'd2 && n < 100) begin
      @(negedge clkin);
      n++;
    end
    pop_chk(state);
    push("t6_pll_rst", 1); push("t6_sys_rst_n", 0); push("t6_lock_ok", 0);
    push("t6_fault", 0); push("t6_retry", 0); push("t6_state", 0);
    repeat (10) @(posedge clkin);
    #3;
    rst_n = 1'b0;
    #1;
    pop_chk(pll_rst); pop_chk(sys_rst_n); pop_chk(lock_ok);
    pop_chk(fault); pop_chk(retry_cnt); pop_chk(state);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
